serial_byte_loader: RTL and testbench

Serial-to-parallel front end for the bit-count datapath. Collects a framed serial bit stream into a WIDTH-bit word and presents it on `a` with a one-cycle `load` strobe. It sits directly upstream of the popcount stage, which captures `a` whenever `load` is high. It also detects aborted and stalled frames and, optionally, even-parity errors.

---
 rtl/serial_byte_loader.sv | 90 +++++++++
 tb/tb_serial_byte_loader.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/serial_byte_loader.sv
// serial_byte_loader: frames a serial bit stream into a WIDTH-bit word with load strobe; define SERIAL_PARITY_CHECK_EN for a trailing even-parity bit.
module serial_byte_loader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] a,
  output logic             load,
  output logic             busy,
  output logic             frame_err,
  output logic             parity_err
);
  localparam int BW = $clog2(WIDTH);
  localparam int IW = $clog2(TIMEOUT + 1);
`ifdef SERIAL_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t           r_state, w_state_nx;
  logic [BW-1:0]    r_bit;
  logic [IW-1:0]    r_idle;
  logic [WIDTH-1:0] r_sr, r_a, w_sr_nx, w_word;
  logic             r_load, r_ferr, r_perr;
  logic             w_busy, w_to, w_take, w_last, w_load, w_perr;
  assign w_busy  = r_state != IDLE;
  assign w_to    = w_busy && !start && !din_valid && r_idle == IW'(TIMEOUT - 1);
  assign w_take  = r_state == SHIFT && !start && din_valid;
  assign w_last  = w_take && r_bit == BW'(WIDTH - 1);
  assign w_sr_nx = MSB_FIRST ? {r_sr[WIDTH-2:0], din} : {din, r_sr[WIDTH-1:1]};
`ifdef SERIAL_PARITY_CHECK_EN
  logic w_ptake, w_pok;
  assign w_ptake = r_state == PARITY && !start && din_valid;
  assign w_pok   = ~^{r_sr, din};
  assign w_load  = w_ptake && w_pok;
  assign w_perr  = w_ptake && !w_pok;
  assign w_word  = r_sr;
`else
  assign w_load  = w_last;
  assign w_perr  = 1'b0;
  assign w_word  = w_sr_nx;
`endif
  always_comb begin
    w_state_nx = r_state;
    if (start) w_state_nx = SHIFT;
    else if (w_to) w_state_nx = IDLE;
`ifdef SERIAL_PARITY_CHECK_EN
    else if (w_last) w_state_nx = PARITY;
    else if (w_ptake) w_state_nx = IDLE;
`else
    else if (w_last) w_state_nx = IDLE;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_idle  <= '0;
      r_sr    <= '0;
      r_a     <= '0;
      r_load  <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_load  <= w_load;
      r_ferr  <= (w_busy && start) || w_to;
      r_perr  <= w_perr;
      if (w_load) r_a <= w_word;
      if (w_take) r_sr <= w_sr_nx;
      if (start) begin
        r_bit  <= '0;
        r_idle <= '0;
      end else if (w_busy) begin
        r_idle <= din_valid ? '0 : r_idle + 1'b1;
        if (w_take) r_bit <= r_bit + 1'b1;
      end
    end
  end
  assign a          = r_a;
  assign load       = r_load;
  assign busy       = w_busy;
  assign frame_err  = r_ferr;
  assign parity_err = r_perr;
endmodule

// File: tb/tb_serial_byte_loader.sv
// tb_serial_byte_loader: directed checks of framing, latency, abort, timeout and reset (parity cases when the macro is defined).
module tb_serial_byte_loader;
`ifdef SERIAL_PARITY_CHECK_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = PAR ? 9 : 8;
  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, din = 1'b0, din_valid = 1'b0;
  logic [7:0] a_m, a_l;
  logic       load, busy, frame_err, parity_err;
  logic       load_l, busy_l, ferr_l, perr_l;
  int         n_tests = 0, n_fail = 0;
  int         n_load, n_ferr, n_perr, n_busy;
  always #5 clk = ~clk;
  serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b1), .TIMEOUT(16)) u_msb (
    .clk(clk), .reset(reset), .start(start), .din(din), .din_valid(din_valid),
    .a(a_m), .load(load), .busy(busy), .frame_err(frame_err), .parity_err(parity_err));
  serial_byte_loader #(.WIDTH(8), .MSB_FIRST(1'b0), .TIMEOUT(16)) u_lsb (
    .clk(clk), .reset(reset), .start(start), .din(din), .din_valid(din_valid),
    .a(a_l), .load(load_l), .busy(busy_l), .frame_err(ferr_l), .parity_err(perr_l));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    n_load = 0; n_ferr = 0; n_perr = 0; n_busy = 0;
  endtask
  // Inputs held for one cycle; outputs sampled at the following falling edge.
  task automatic drv(input logic s, input logic v, input logic d);
    start = s; din_valid = v; din = d;
    @(negedge clk);
    n_load += int'(load);
    n_ferr += int'(frame_err);
    n_perr += int'(parity_err);
    n_busy += int'(busy);
  endtask
  task automatic bits(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) drv(1'b0, 1'b1, b[i]);
  endtask
  task automatic par(input logic [7:0] b);
    if (PAR) drv(1'b0, 1'b1, ^b);
  endtask
  initial begin
    clr();
    @(negedge clk);
    drv(1'b0, 1'b0, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    chk("rst_a", a_m, 8'h00);
    chk("rst_load", load, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", {frame_err, parity_err}, 2'b00);
    reset = 1'b0;
    clr();
    drv(1'b1, 1'b0, 1'b0);
    chk("t1_busy1", busy, 1'b1);
    bits(8'hB2, 7, 1);
    chk("t1_early", load, 1'b0);
    bits(8'hB2, 0, 0);
    par(8'hB2);
    chk("t1_load", load, 1'b1);
    chk("t1_a_msb", a_m, 8'hB2);
    chk("t1_a_lsb", a_l, 8'h4D);
    chk("t1_load_lsb", load_l, 1'b1);
    chk("t1_busy_end", busy, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    chk("t1_load_off", load, 1'b0);
    chk("t1_nload", n_load, 1);
    chk("t1_nbusy", n_busy, NB);
    chk("t1_nerr", n_ferr + n_perr, 0);
    clr();
    drv(1'b1, 1'b0, 1'b0);
    bits(8'hB2, 7, 4);
    repeat (3) drv(1'b0, 1'b0, 1'b0);
    bits(8'hB2, 3, 1);
    chk("gap_early", n_load, 0);
    bits(8'hB2, 0, 0);
    par(8'hB2);
    chk("gap_load", load, 1'b1);
    chk("gap_a", a_m, 8'hB2);
    chk("gap_nbusy", n_busy, NB + 3);
    clr();
    drv(1'b1, 1'b0, 1'b0);
    bits(8'hA5, 7, 4);
    drv(1'b1, 1'b1, 1'b1);
    chk("abort_ferr", frame_err, 1'b1);
    chk("abort_busy", busy, 1'b1);
    bits(8'hFF, 7, 1);
    chk("abort_a_held_m", a_m, 8'hB2);
    chk("abort_a_held_l", a_l, 8'h4D);
    chk("abort_noload", n_load, 0);
    bits(8'hFF, 0, 0);
    par(8'hFF);
    chk("abort_load", load, 1'b1);
    chk("abort_a_m", a_m, 8'hFF);
    chk("abort_a_l", a_l, 8'hFF);
    chk("abort_nferr", n_ferr, 1);
    clr();
    drv(1'b1, 1'b0, 1'b0);
    bits(8'h55, 7, 3);
    repeat (15) drv(1'b0, 1'b0, 1'b0);
    chk("to_busy_pre", busy, 1'b1);
    chk("to_nferr_pre", n_ferr, 0);
    drv(1'b0, 1'b0, 1'b0);
    chk("to_ferr", frame_err, 1'b1);
    chk("to_busy", busy, 1'b0);
    drv(1'b0, 1'b0, 1'b0);
    chk("to_ferr_off", frame_err, 1'b0);
    chk("to_noload", n_load, 0);
    chk("to_a", a_m, 8'hFF);
    clr();
    drv(1'b1, 1'b0, 1'b0);
    bits(8'h3C, 7, 2);
    reset = 1'b1;
    drv(1'b0, 1'b1, 1'b1);
    chk("mrst_a", a_m, 8'h00);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_pulses", {load, frame_err, parity_err}, 3'b000);
    reset = 1'b0;
    bits(8'h3C, 1, 0);
    repeat (4) drv(1'b0, 1'b0, 1'b0);
    chk("mrst_noload", n_load, 0);
    chk("mrst_idle", busy, 1'b0);
`ifdef SERIAL_PARITY_CHECK_EN
    clr();
    drv(1'b1, 1'b0, 1'b0);
    bits(8'hB2, 7, 0);
    drv(1'b0, 1'b1, 1'b0);
    chk("par_ok_load", load, 1'b1);
    chk("par_ok_a", a_m, 8'hB2);
    clr();
    drv(1'b1, 1'b0, 1'b0);
    bits(8'h0F, 7, 0);
    drv(1'b0, 1'b1, 1'b1);
    chk("par_bad_perr", parity_err, 1'b1);
    chk("par_bad_load", load, 1'b0);
    chk("par_bad_a", a_m, 8'hB2);
    drv(1'b0, 1'b0, 1'b0);
    chk("par_bad_counts", {n_load[7:0], n_perr[7:0]}, 16'h0001);
`else
    chk("noparity_tied", n_perr, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
